// File: rtl/servo_pwm_bank_if.sv
// Write port, enable requests and PWM status outputs of servo_pwm_bank.
interface servo_pwm_bank_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CW   = 11,
  parameter int unsigned CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic            wr_en;
  logic [CHW-1:0]  wr_ch;
  logic [CW-1:0]   wr_data;
  logic [N_CH-1:0] ch_en;
  logic [N_CH-1:0] sig;
  logic [N_CH-1:0] pending;
  logic            frame_start;

  modport master (
    output wr_en, wr_ch, wr_data, ch_en,
    input  sig, pending, frame_start
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, ch_en,
    output sig, pending, frame_start
  );
endinterface

// File: rtl/servo_pwm_bank.sv
// Bank of servo PWM channels sharing one frame counter; pulse widths and
// enables are double-buffered and committed only at the frame wrap.
module servo_pwm_bank #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CW     = 11,
  parameter int unsigned DIV    = 500,
  parameter int unsigned FRAME  = 2000,
  parameter int unsigned PW_MIN = 50,
  parameter int unsigned PW_MAX = 250,
  parameter int unsigned CHW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic clk,
  input  logic rst_n,
  servo_pwm_bank_if.slave bus
);

  localparam int unsigned PSW = $clog2(DIV);

  logic [PSW-1:0]  r_presc;
  logic [CW-1:0]   r_frame;
  logic [CW-1:0]   r_shadow [N_CH];
  logic [CW-1:0]   r_active [N_CH];
  logic [N_CH-1:0] r_en_act;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_sig;
  logic            r_frame_start;

  logic            w_tick;
  logic            w_commit;
  logic            w_wr_ok;
  logic [CW-1:0]   w_clamped;

  assign w_tick   = (r_presc == PSW'(DIV - 1));
  assign w_commit = w_tick && (r_frame == CW'(FRAME - 1));
  assign w_wr_ok  = bus.wr_en && (32'(bus.wr_ch) < N_CH);

  // Clamp requested width: zero keeps the channel off, otherwise bound to PW_MIN..PW_MAX
  always_comb begin
    w_clamped = bus.wr_data;
    if (bus.wr_data == '0) begin
      w_clamped = '0;
    end else if (bus.wr_data < CW'(PW_MIN)) begin
      w_clamped = CW'(PW_MIN);
    end else if (bus.wr_data > CW'(PW_MAX)) begin
      w_clamped = CW'(PW_MAX);
    end
  end

  // Prescaler: 0..DIV-1, tick on the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PSW'(1);
    end
  end

  // Shared frame counter advancing once per tick, wrapping at FRAME-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else if (w_tick) begin
      if (r_frame == CW'(FRAME - 1)) begin
        r_frame <= '0;
      end else begin
        r_frame <= r_frame + CW'(1);
      end
    end
  end

  // Frame-start strobe in the cycle following the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_commit;
    end
  end

  // Shadow/active double buffer; a write on the commit cycle lands in shadow
  // after active has taken the previous shadow value, so it stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_en_act  <= '0;
      r_pending <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (w_commit) begin
          r_active[i]  <= r_shadow[i];
          r_en_act[i]  <= bus.ch_en[i];
          r_pending[i] <= 1'b0;
        end
        if (w_wr_ok && (bus.wr_ch == CHW'(i))) begin
          r_shadow[i]  <= w_clamped;
          r_pending[i] <= 1'b1;
        end
      end
    end
  end

  // Registered PWM compare against the shared frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_sig[i] <= r_en_act[i] && (r_frame < r_active[i]);
      end
    end
  end

  assign bus.sig         = r_sig;
  assign bus.pending     = r_pending;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank: a monitor measures each frame
// (period and per-channel high cycles); tests queue the expected frames.
module tb_servo_pwm_bank;

  localparam int N_CH   = 4;
  localparam int CW     = 11;
  localparam int DIV    = 4;
  localparam int FRAME  = 20;
  localparam int PW_MIN = 2;
  localparam int PW_MAX = 15;
  localparam int CHW    = 3;
  localparam int PERIOD = FRAME * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  servo_pwm_bank_if #(.N_CH(N_CH), .CW(CW), .CHW(CHW)) bus ();

  servo_pwm_bank #(
    .N_CH(N_CH), .CW(CW), .DIV(DIV), .FRAME(FRAME),
    .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .CHW(CHW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] h0;
    logic [15:0] h1;
    logic [15:0] h2;
    logic [15:0] h3;
  } meas_t;

  meas_t obs_q[$];
  meas_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference: high cycles per frame for a requested width
  function automatic int model_hi(input int req);
    if (req == 0)      return 0;
    if (req < PW_MIN)  return PW_MIN * DIV;
    if (req > PW_MAX)  return PW_MAX * DIV;
    return req * DIV;
  endfunction

  function automatic meas_t mk(input int a, input int b, input int c, input int d);
    meas_t m;
    m.period = 16'(PERIOD);
    m.h0 = 16'(a);
    m.h1 = 16'(b);
    m.h2 = 16'(c);
    m.h3 = 16'(d);
    return m;
  endfunction

  function automatic string fmt(input meas_t m);
    return $sformatf("period=%0d hi=%0d/%0d/%0d/%0d", m.period, m.h0, m.h1, m.h2, m.h3);
  endfunction

  // Frame monitor: sampled 1 ns after each rising edge
  int    m_cyc;
  int    m_hi [N_CH];
  bit    m_in = 1'b0;
  meas_t m_tmp;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_in = 1'b0;
    end else if (bus.frame_start) begin
      if (m_in) begin
        m_tmp.period = 16'(m_cyc);
        m_tmp.h0 = 16'(m_hi[0]);
        m_tmp.h1 = 16'(m_hi[1]);
        m_tmp.h2 = 16'(m_hi[2]);
        m_tmp.h3 = 16'(m_hi[3]);
        obs_q.push_back(m_tmp);
      end
      m_cyc = 1;
      for (int i = 0; i < N_CH; i++) m_hi[i] = int'(bus.sig[i]);
      m_in = 1'b1;
    end else begin
      m_cyc++;
      for (int i = 0; i < N_CH; i++) m_hi[i] += int'(bus.sig[i]);
    end
  end

  task automatic do_write(input int ch, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = CHW'(ch);
    bus.wr_data = CW'(data);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Advance to the negedge of the next frame_start cycle and drop stale frames
  task automatic sync_frame(input string who);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.frame_start && k < 200);
    if (!bus.frame_start) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sync: no frame_start within %0d cycles", who, k);
    end
    obs_q.delete();
  endtask

  task automatic get_obs(output meas_t m, output bit ok);
    m  = '0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (obs_q.size() > 0) break;
      @(negedge clk);
    end
    if (obs_q.size() > 0) begin
      m  = obs_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Release reset at a negedge; count edges up to the first frame_start
  task automatic release_and_count(output int cnt, output int hi);
    cnt   = 0;
    hi    = 0;
    rst_n = 1'b1;
    while (cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
      if (bus.frame_start) break;
      hi += $countones(bus.sig);
    end
  endtask

  task automatic test_reset();
    int cnt, hi;
    meas_t e, o;
    bit ok;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_data = '0;
    bus.ch_en   = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.sig, bus.pending, bus.frame_start} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: sig=%b pending=%b fs=%b, want all 0",
               bus.sig, bus.pending, bus.frame_start);
    end
    release_and_count(cnt, hi);
    n_cmp++;
    if (cnt !== PERIOD) begin
      n_err++;
      $display("FAIL reset_first_commit: %0d edges, want %0d", cnt, PERIOD);
    end
    n_cmp++;
    if (hi !== 0) begin
      n_err++;
      $display("FAIL reset_idle_sig: %0d high samples, want 0", hi);
    end
    exp_q.push_back(mk(0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      n_cmp++;
      if (!ok || o !== e) begin
        n_err++;
        $display("FAIL reset_frame: got ok=%0d %s, want %s", ok, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_single_channel();
    logic [N_CH-1:0] prev;
    int k = 0;
    meas_t e, o;
    bit ok;
    sync_frame("single");
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(model_hi(5), 0, 0, 0));
    bus.ch_en = 4'b0001;
    do_write(0, 5);
    n_cmp++;
    if (bus.pending !== 4'b0001) begin
      n_err++;
      $display("FAIL single_pending_set: pending=%b, want 0001", bus.pending);
    end
    prev = bus.pending;
    while (!bus.frame_start && k < 200) begin
      prev = bus.pending;
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (prev !== 4'b0001) begin
      n_err++;
      $display("FAIL single_pending_hold: pending=%b before commit, want 0001", prev);
    end
    n_cmp++;
    if (bus.pending !== 4'b0000 || !bus.frame_start) begin
      n_err++;
      $display("FAIL single_pending_clear: pending=%b fs=%b, want 0000 1",
               bus.pending, bus.frame_start);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      n_cmp++;
      if (!ok || o !== e) begin
        n_err++;
        $display("FAIL single_frame: got ok=%0d %s, want %s", ok, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_multi_clamp();
    meas_t e, o;
    bit ok;
    sync_frame("multi");
    exp_q.push_back(mk(model_hi(5), 0, 0, 0));
    exp_q.push_back(mk(model_hi(5), model_hi(1), model_hi(30), model_hi(0)));
    bus.ch_en = 4'b1111;
    do_write(1, 1);
    do_write(2, 30);
    do_write(3, 0);
    n_cmp++;
    if (bus.pending !== 4'b1110) begin
      n_err++;
      $display("FAIL multi_pending: pending=%b, want 1110", bus.pending);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      n_cmp++;
      if (!ok || o !== e) begin
        n_err++;
        $display("FAIL multi_frame: got ok=%0d %s, want %s", ok, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_commit_write();
    meas_t e, o;
    bit ok;
    sync_frame("commit");
    exp_q.push_back(mk(model_hi(5), model_hi(1), model_hi(30), 0));
    exp_q.push_back(mk(model_hi(5), model_hi(1), model_hi(30), 0));
    exp_q.push_back(mk(model_hi(10), model_hi(1), model_hi(30), 0));
    repeat (PERIOD - 1) @(negedge clk);
    do_write(0, 10);
    n_cmp++;
    if (bus.frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL commit_align: fs=%b after write, want 1", bus.frame_start);
    end
    n_cmp++;
    if (bus.pending !== 4'b0001) begin
      n_err++;
      $display("FAIL commit_pending: pending=%b, want 0001", bus.pending);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      n_cmp++;
      if (!ok || o !== e) begin
        n_err++;
        $display("FAIL commit_frame: got ok=%0d %s, want %s", ok, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_oor_disable();
    meas_t e, o;
    bit ok;
    sync_frame("oor");
    exp_q.push_back(mk(model_hi(10), model_hi(1), model_hi(30), 0));
    exp_q.push_back(mk(model_hi(10), model_hi(1), 0, 0));
    do_write(5, 7);
    n_cmp++;
    if (bus.pending !== 4'b0000) begin
      n_err++;
      $display("FAIL oor_pending: pending=%b, want 0000", bus.pending);
    end
    repeat (8) @(negedge clk);
    bus.ch_en = 4'b1011;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      n_cmp++;
      if (!ok || o !== e) begin
        n_err++;
        $display("FAIL oor_frame: got ok=%0d %s, want %s", ok, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt, hi;
    meas_t e, o;
    bit ok;
    sync_frame("rstmid");
    do_write(3, 12);
    n_cmp++;
    if (bus.pending !== 4'b1000) begin
      n_err++;
      $display("FAIL rstmid_pending_pre: pending=%b, want 1000", bus.pending);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.sig[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pulse_pre: sig=%b, want sig[0]=1", bus.sig);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.sig !== 4'b0000 || bus.pending !== 4'b0000) begin
      n_err++;
      $display("FAIL rstmid_async: sig=%b pending=%b, want 0000 0000", bus.sig, bus.pending);
    end
    obs_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    release_and_count(cnt, hi);
    n_cmp++;
    if (cnt !== PERIOD) begin
      n_err++;
      $display("FAIL rstmid_first_commit: %0d edges, want %0d", cnt, PERIOD);
    end
    n_cmp++;
    if (hi !== 0) begin
      n_err++;
      $display("FAIL rstmid_idle_sig: %0d high samples, want 0", hi);
    end
    exp_q.push_back(mk(0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs(o, ok);
      n_cmp++;
      if (!ok || o !== e) begin
        n_err++;
        $display("FAIL rstmid_frame: got ok=%0d %s, want %s", ok, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_multi_clamp();
    test_commit_write();
    test_oor_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
